// File: rtl/vga_line_fetcher.sv
// Fetches one image row from word-addressed RAM into a ping-pong line buffer
// and streams it out as RGB888 pixels with valid/ready handshaking.
module vga_line_fetcher #(
    parameter int unsigned ADDR_W    = 15,
    parameter int unsigned H_PIXELS  = 160,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned PACK_MODE = 0,
    parameter int unsigned RD_LAT    = 1
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic              line_req,
    input  logic [15:0]       line_row,
    output logic              line_busy,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_chipselect,
    output logic              ram_clken,
    output logic              ram_write,
    output logic [3:0]        ram_byteenable,
    input  logic [31:0]       ram_readdata,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [23:0]       pix_data,
    output logic              pix_last,
    output logic              err_overrun
);

    localparam int unsigned WORDS = (PACK_MODE != 0) ? H_PIXELS / 2 : H_PIXELS;
    localparam int unsigned IDX_W = $clog2(H_PIXELS);
    localparam logic [IDX_W-1:0] W_LAST   = IDX_W'(WORDS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(H_PIXELS - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StFlush, StCommit} state_e;
    typedef enum logic [1:0] {BankEmpty, BankFilling, BankFull} bank_e;

    state_e state_q, state_d;
    bank_e  bank_q [2];
    bank_e  bank_d [2];

    logic              fill_bank_q;
    logic [IDX_W-1:0]  k_q, wr_k_q;
    logic [ADDR_W-1:0] addr_q;
    logic [RD_LAT-1:0] rv_q, rv_d;
    logic              err_q;
    logic [23:0]       mem_q [2][H_PIXELS];

    logic              pix_valid_q, pix_valid_d;
    logic              pix_last_q, pix_last_d;
    logic [23:0]       pix_data_q, pix_data_d;
    logic              rd_bank_q, rd_bank_d;
    logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
    logic              bank_release;

    logic              any_empty, accept, free_bank, issue, capture, last_capture, xfer;
    logic [31:0]       row_addr;
    logic [IDX_W:0]    wr_pair;
    logic              unused_bits;

    function automatic logic [23:0] rgb565_to_888(input logic [15:0] p);
        return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
    endfunction

    assign any_empty    = (bank_q[0] == BankEmpty) || (bank_q[1] == BankEmpty);
    assign accept       = line_req && (state_q == StIdle) && any_empty;
    assign free_bank    = (bank_q[0] == BankEmpty) ? 1'b0 : 1'b1;
    assign issue        = (state_q == StIssue);
    assign capture      = rv_q[RD_LAT-1];
    assign last_capture = capture && (wr_k_q == W_LAST);
    assign xfer         = pix_valid_q && pix_ready;
    // Row start address is formed at 32 bits and only then truncated to ADDR_W.
    assign row_addr     = 32'(BASE_ADDR) + 32'(line_row) * 32'(WORDS);
    assign wr_pair      = {wr_k_q, 1'b0};
    assign unused_bits  = ^{ram_readdata, row_addr, wr_pair};

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (accept) state_d = StIssue;
            StIssue:  if (k_q == W_LAST) state_d = StFlush;
            StFlush:  if (last_capture) state_d = StCommit;
            StCommit: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        ram_chipselect = issue;
        ram_clken      = issue;
        ram_address    = issue ? addr_q : '0;
        line_busy      = !((state_q == StIdle) && any_empty);
    end

    assign ram_write      = 1'b0;
    assign ram_byteenable = 4'hF;

    always_comb begin
        rv_d    = '0;
        rv_d[0] = issue;
        for (int i = 1; i < RD_LAT; i++) begin
            rv_d[i] = rv_q[i-1];
        end
    end

    always_comb begin
        pix_valid_d  = pix_valid_q;
        pix_last_d   = pix_last_q;
        pix_data_d   = pix_data_q;
        rd_bank_d    = rd_bank_q;
        rd_idx_d     = rd_idx_q;
        bank_release = 1'b0;
        if (!pix_valid_q) begin
            if ((bank_q[0] == BankFull) || (bank_q[1] == BankFull)) begin
                rd_bank_d   = (bank_q[0] == BankFull) ? 1'b0 : 1'b1;
                rd_idx_d    = '0;
                pix_valid_d = 1'b1;
                pix_last_d  = 1'b0;
                pix_data_d  = mem_q[rd_bank_d][rd_idx_d];
            end
        end else if (xfer) begin
            if (pix_last_q) begin
                bank_release = 1'b1;
                pix_last_d   = 1'b0;
                // Chain straight into the other bank so there is no bubble.
                if (bank_q[~rd_bank_q] == BankFull) begin
                    rd_bank_d  = ~rd_bank_q;
                    rd_idx_d   = '0;
                    pix_data_d = mem_q[rd_bank_d][rd_idx_d];
                end else begin
                    pix_valid_d = 1'b0;
                end
            end else begin
                rd_idx_d   = rd_idx_q + 1'b1;
                pix_data_d = mem_q[rd_bank_q][rd_idx_d];
                pix_last_d = (rd_idx_d == IDX_LAST);
            end
        end
    end

    always_comb begin
        bank_d = bank_q;
        if (accept) bank_d[free_bank] = BankFilling;
        if (state_q == StCommit) bank_d[fill_bank_q] = BankFull;
        if (bank_release) bank_d[rd_bank_q] = BankEmpty;
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            bank_q      <= '{BankEmpty, BankEmpty};
            fill_bank_q <= 1'b0;
            k_q         <= '0;
            wr_k_q      <= '0;
            addr_q      <= '0;
            rv_q        <= '0;
            err_q       <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_last_q  <= 1'b0;
            pix_data_q  <= '0;
            rd_bank_q   <= 1'b0;
            rd_idx_q    <= '0;
        end else begin
            bank_q      <= bank_d;
            rv_q        <= rv_d;
            pix_valid_q <= pix_valid_d;
            pix_last_q  <= pix_last_d;
            pix_data_q  <= pix_data_d;
            rd_bank_q   <= rd_bank_d;
            rd_idx_q    <= rd_idx_d;
            if (accept) begin
                addr_q      <= row_addr[ADDR_W-1:0];
                k_q         <= '0;
                wr_k_q      <= '0;
                fill_bank_q <= free_bank;
            end
            if (issue) begin
                addr_q <= addr_q + 1'b1;
                k_q    <= k_q + 1'b1;
            end
            if (capture) wr_k_q <= wr_k_q + 1'b1;
            if (line_req && !accept) err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (capture) begin
            if (PACK_MODE == 0) begin
                mem_q[fill_bank_q][wr_k_q] <= ram_readdata[23:0];
            end else begin
                mem_q[fill_bank_q][{wr_pair[IDX_W-1:1], 1'b0}] <= rgb565_to_888(ram_readdata[15:0]);
                mem_q[fill_bank_q][{wr_pair[IDX_W-1:1], 1'b1}] <= rgb565_to_888(ram_readdata[31:16]);
            end
        end
    end

    assign pix_valid   = pix_valid_q;
    assign pix_last    = pix_last_q;
    assign pix_data    = pix_data_q;
    assign err_overrun = err_q;

endmodule

// File: tb/tb_vga_line_fetcher.sv
// Directed bench: RGB888 instance (4-bit address, wraps) and RGB565 instance
// with two-cycle read latency, checked against hand-derived values.
module tb_vga_line_fetcher;

    logic clk, rst;

    logic        a_req, a_busy, a_cs, a_clken, a_write, a_valid, a_ready, a_last, a_err;
    logic [15:0] a_row;
    logic [3:0]  a_addr, a_be;
    logic [31:0] a_rdata;
    logic [23:0] a_data;

    logic        b_req, b_busy, b_cs, b_clken, b_write, b_valid, b_ready, b_last, b_err;
    logic [15:0] b_row;
    logic [14:0] b_addr;
    logic [3:0]  b_be;
    logic [31:0] b_rdata, b_p1;
    logic [23:0] b_data;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    vga_line_fetcher #(
        .ADDR_W(4), .H_PIXELS(4), .BASE_ADDR(0), .PACK_MODE(0), .RD_LAT(1)
    ) u_dut_a (
        .clk_clk(clk), .reset_reset(rst), .line_req(a_req), .line_row(a_row),
        .line_busy(a_busy), .ram_address(a_addr), .ram_chipselect(a_cs),
        .ram_clken(a_clken), .ram_write(a_write), .ram_byteenable(a_be),
        .ram_readdata(a_rdata), .pix_valid(a_valid), .pix_ready(a_ready),
        .pix_data(a_data), .pix_last(a_last), .err_overrun(a_err)
    );

    vga_line_fetcher #(
        .ADDR_W(15), .H_PIXELS(4), .BASE_ADDR(100), .PACK_MODE(1), .RD_LAT(2)
    ) u_dut_b (
        .clk_clk(clk), .reset_reset(rst), .line_req(b_req), .line_row(b_row),
        .line_busy(b_busy), .ram_address(b_addr), .ram_chipselect(b_cs),
        .ram_clken(b_clken), .ram_write(b_write), .ram_byteenable(b_be),
        .ram_readdata(b_rdata), .pix_valid(b_valid), .pix_ready(b_ready),
        .pix_data(b_data), .pix_last(b_last), .err_overrun(b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ram_a(input logic [3:0] a);
        return {8'h5A, 4'h1, a, 4'h2, a, 4'h3, a};
    endfunction

    function automatic logic [31:0] ram_b(input logic [14:0] a);
        case (a)
            15'd102: return 32'hF800_07E0;
            15'd103: return 32'h001F_FFFF;
            default: return 32'h1234_5678;
        endcase
    endfunction

    // Poison value on idle cycles exposes captures taken at the wrong latency.
    always @(posedge clk) a_rdata <= a_cs ? ram_a(a_addr) : 32'h0BAD_0BAD;
    always @(posedge clk) begin
        b_p1    <= b_cs ? ram_b(b_addr) : 32'h0BAD_0BAD;
        b_rdata <= b_p1;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        a_req = 1'b0; a_row = '0; a_ready = 1'b1;
        b_req = 1'b0; b_row = '0; b_ready = 1'b1;
        tick(); tick();
        chk("rst_valid", a_valid, 0);
        chk("rst_last", a_last, 0);
        chk("rst_cs", a_cs, 0);
        chk("rst_clken", a_clken, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_err", a_err, 0);
        chk("rst_addr", a_addr, 0);
        chk("rst_data", a_data, 0);
        chk("rst_write", a_write, 0);
        chk("rst_be", a_be, 4'hF);
        chk("rst_b_valid", b_valid, 0);
        chk("rst_b_busy", b_busy, 0);
        chk("rst_b_clken", b_clken, 0);
        chk("rst_b_write", b_write, 0);
        chk("rst_b_be", b_be, 4'hF);
        chk("rst_b_err", b_err, 0);
        rst = 1'b0;
        tick();

        // Row 3, RGB888: addresses 12..15, pixels straight from readdata.
        a_req = 1'b1; a_row = 16'd3;
        for (int k = 0; k < 4; k++) begin
            tick(); a_req = 1'b0;
            chk("t1_addr", a_addr, 32'(12 + k));
            chk("t1_cs", a_cs, 1);
            chk("t1_busy", a_busy, 1);
        end
        tick(); chk("t1_flush_cs", a_cs, 0);
        tick(); chk("t1_commit_valid", a_valid, 0);
        tick(); chk("t1_early_valid", a_valid, 0);
        chk("t1_idle_busy", a_busy, 0);
        for (int p = 0; p < 4; p++) begin
            tick();
            chk("t1_valid", a_valid, 1);
            chk("t1_data", a_data, 24'h1C2C3C + 24'(p) * 24'h010101);
            chk("t1_last", a_last, 32'(p == 3));
        end
        tick(); chk("t1_end_valid", a_valid, 0);

        // Row 5 wraps to 4..7 in 4-bit space; stall three cycles on pixel 2.
        a_req = 1'b1; a_row = 16'd5;
        for (int k = 0; k < 4; k++) begin
            tick(); a_req = 1'b0;
            chk("t2_wrap_addr", a_addr, 32'(4 + k));
        end
        repeat (4) tick();
        chk("t2_p0", a_data, 24'h142434);
        chk("t2_p0_valid", a_valid, 1);
        tick(); chk("t2_p1", a_data, 24'h152535);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_hold_data", a_data, 24'h162636);
            chk("t2_hold_valid", a_valid, 1);
            chk("t2_hold_last", a_last, 0);
            a_ready = (i == 3);
        end
        tick();
        chk("t2_p3", a_data, 24'h172737);
        chk("t2_p3_last", a_last, 1);
        tick(); chk("t2_end_valid", a_valid, 0);

        // Fill both banks with the sink stalled, then try a third request.
        a_ready = 1'b0; a_req = 1'b1; a_row = 16'd0;
        tick(); a_req = 1'b0;
        repeat (6) tick();
        chk("t3_one_full_busy", a_busy, 0);
        a_req = 1'b1; a_row = 16'd1;
        tick(); a_req = 1'b0;
        chk("t3_held_valid", a_valid, 1);
        chk("t3_held_data", a_data, 24'h102030);
        chk("t3_second_addr", a_addr, 4);
        repeat (6) tick();
        chk("t3_full_busy", a_busy, 1);
        chk("t3_full_err", a_err, 0);
        a_req = 1'b1; a_row = 16'd2;
        tick(); a_req = 1'b0;
        chk("t3_overrun_err", a_err, 1);
        chk("t3_overrun_cs", a_cs, 0);
        chk("t3_overrun_busy", a_busy, 1);
        a_ready = 1'b1;
        for (int p = 0; p < 8; p++) begin
            if (p > 0) tick();
            chk("t3_drain_valid", a_valid, 1);
            chk("t3_drain_data", a_data, 24'h102030 + 24'(p) * 24'h010101);
            chk("t3_drain_last", a_last, 32'((p == 3) || (p == 7)));
            chk("t3_drain_cs", a_cs, 0);
            if (p == 4) chk("t3_freed_busy", a_busy, 0);
        end
        tick();
        chk("t3_end_valid", a_valid, 0);
        chk("t3_err_sticky", a_err, 1);

        // Reset during the second issue cycle, then refetch row 5.
        a_req = 1'b1; a_row = 16'd3;
        tick(); a_req = 1'b0;
        chk("t4_addr0", a_addr, 12);
        tick();
        chk("t4_addr1", a_addr, 13);
        rst = 1'b1;
        tick();
        chk("t4_rst_cs", a_cs, 0);
        chk("t4_rst_clken", a_clken, 0);
        chk("t4_rst_addr", a_addr, 0);
        chk("t4_rst_busy", a_busy, 0);
        chk("t4_rst_valid", a_valid, 0);
        chk("t4_rst_last", a_last, 0);
        chk("t4_rst_data", a_data, 0);
        chk("t4_rst_err", a_err, 0);
        rst = 1'b0;
        tick();
        chk("t4_idle_cs", a_cs, 0);
        a_req = 1'b1; a_row = 16'd5;
        for (int k = 0; k < 4; k++) begin
            tick(); a_req = 1'b0;
            chk("t4_addr", a_addr, 32'(4 + k));
        end
        repeat (3) tick();
        chk("t4_early_valid", a_valid, 0);
        for (int p = 0; p < 4; p++) begin
            tick();
            chk("t4_valid", a_valid, 1);
            chk("t4_data", a_data, 24'h142434 + 24'(p) * 24'h010101);
            chk("t4_last", a_last, 32'(p == 3));
        end
        tick(); chk("t4_end_valid", a_valid, 0);

        // RGB565 packing, base 100, row 1 -> words 102, 103, read latency 2.
        b_req = 1'b1; b_row = 16'd1;
        tick(); b_req = 1'b0;
        chk("t5_addr0", b_addr, 102);
        chk("t5_cs0", b_cs, 1);
        tick(); chk("t5_addr1", b_addr, 103);
        tick(); chk("t5_flush_cs", b_cs, 0);
        tick(); chk("t5_flush_busy", b_busy, 1);
        repeat (2) tick();
        chk("t5_early_valid", b_valid, 0);
        tick();
        chk("t5_p0_valid", b_valid, 1);
        chk("t5_p0", b_data, 24'h00FF00);
        chk("t5_p0_last", b_last, 0);
        tick(); chk("t5_p1", b_data, 24'hFF0000);
        tick(); chk("t5_p2", b_data, 24'hFFFFFF);
        tick();
        chk("t5_p3", b_data, 24'h0000FF);
        chk("t5_p3_last", b_last, 1);
        tick(); chk("t5_end_valid", b_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
